downscale_avg: RTL and testbench

- Streaming 2x2 box-filter decimator. It is the inverse of the 2x upscaling interpolator.
- Accepts a raster frame of h_res x v_res pixels and emits a raster frame of (h_res/2) x (v_res/2) pixels. Each output pixel is the rounded mean of one non-overlapping 2x2 input quad.
- Sits between an upscaled frame stream and a downstream consumer. It applies valid/ready handshaking on both sides.

---
 rtl/downscale_avg_pkg.sv | 19 +
 rtl/downscale_avg_if.sv | 24 ++
 rtl/downscale_avg_row_sum_buffer.sv | 22 ++
 rtl/downscale_avg.sv | 90 +++++++++
 tb/tb_downscale_avg.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/downscale_avg_pkg.sv
// scale_pkg: shared types, default geometry and sizing helpers for the 2x2 box-filter decimator.
package scale_pkg;

    typedef enum logic [1:0] {ROW_EVEN, ROW_ODD, FLUSH} state_t;

    localparam int BIT_DEPTH = 8;
    localparam int H_RES     = 8;
    localparam int V_RES     = 8;
    localparam int OUT_H_RES = H_RES / 2;
    localparam int OUT_V_RES = V_RES / 2;
    localparam int SUM_W     = BIT_DEPTH + 1;
    localparam int QUAD_W    = BIT_DEPTH + 2;

    // Index width that stays at least one bit for tiny ranges.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/downscale_avg_if.sv
// downscale_avg_if: input/output valid-ready streams plus the frame_done pulse.
interface downscale_avg_if
    import scale_pkg::*;
#(
    parameter int bit_depth = BIT_DEPTH
);
    logic                 valid_in;
    logic [bit_depth-1:0] data_in;
    logic                 ready_out;
    logic                 valid_out;
    logic [bit_depth-1:0] data_out;
    logic                 ready_in;
    logic                 frame_done;

    modport master (
        output valid_in, data_in, ready_in,
        input  ready_out, valid_out, data_out, frame_done
    );

    modport slave (
        input  valid_in, data_in, ready_in,
        output ready_out, valid_out, data_out, frame_done
    );
endinterface

// File: rtl/downscale_avg_row_sum_buffer.sv
// row_sum_buffer: one row of horizontal pair sums, written on even rows and read back on odd rows.
module row_sum_buffer
    import scale_pkg::*;
#(
    parameter int depth = OUT_H_RES,
    parameter int width = SUM_W,
    parameter int aw    = idx_w(OUT_H_RES)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    addr,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata
);
    logic [width-1:0] mem [depth];

    always_ff @(posedge clk)
        if (we)
            mem[addr] <= wdata;

    assign rdata = mem[addr];
endmodule

// File: rtl/downscale_avg.sv
// downscale_avg: streaming 2x2 box-filter decimator with round-half-up averaging.
module downscale_avg
    import scale_pkg::*;
#(
    parameter int bit_depth = BIT_DEPTH,
    parameter int h_res     = H_RES,
    parameter int v_res     = V_RES
) (
    input logic            clk,
    input logic            reset,
    downscale_avg_if.slave bus
);
    localparam int out_h_res = h_res / 2;
    localparam int sum_w     = bit_depth + 1;
    localparam int quad_w    = bit_depth + 2;
    localparam int hw        = idx_w(h_res);
    localparam int vw        = idx_w(v_res);
    localparam int aw        = idx_w(out_h_res);

    state_t               state, state_nx;
    logic [hw-1:0]        h_count;
    logic [vw-1:0]        v_count;
    logic [bit_depth-1:0] pair_reg;
    logic [sum_w-1:0]     pair_sum, buf_rd;
    logic [quad_w-1:0]    quad_rnd;
    logic                 xfer_in, xfer_out, odd_col, last_col, last_row, buf_we, load_out;

    assign xfer_in  = bus.valid_in && bus.ready_out;
    assign xfer_out = bus.valid_out && bus.ready_in;
    assign odd_col  = h_count[0];
    assign last_col = h_count == hw'(h_res - 1);
    assign last_row = v_count == vw'(v_res - 1);
    assign pair_sum = sum_w'(pair_reg) + sum_w'(bus.data_in);
    // +2 before the shift rounds half up; the sum cannot exceed quad_w bits.
    assign quad_rnd = quad_w'(buf_rd) + quad_w'(pair_sum) + quad_w'(2);
    assign load_out = xfer_in && odd_col && state == ROW_ODD;

    row_sum_buffer #(
        .depth(out_h_res),
        .width(sum_w),
        .aw   (aw)
    ) u_row_buf (
        .clk  (clk),
        .we   (buf_we),
        .addr (aw'(h_count >> 1)),
        .wdata(pair_sum),
        .rdata(buf_rd)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            state <= ROW_EVEN;
        else
            state <= state_nx;

    always_comb begin
        state_nx = (state == ROW_EVEN && xfer_in && last_col) ? ROW_ODD :
                   (state == ROW_ODD && xfer_in && last_col)  ? (last_row ? FLUSH : ROW_EVEN) :
                   (state == FLUSH && xfer_out)               ? ROW_EVEN : state;
    end

    always_comb begin
        bus.ready_out  = (!bus.valid_out || bus.ready_in) && state != FLUSH;
        bus.frame_done = state == FLUSH && xfer_out;
        buf_we         = xfer_in && odd_col && state == ROW_EVEN;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            h_count       <= '0;
            v_count       <= '0;
            pair_reg      <= '0;
            bus.valid_out <= 1'b0;
            bus.data_out  <= '0;
        end else begin
            if (bus.frame_done) begin
                h_count <= '0;
                v_count <= '0;
            end else if (xfer_in) begin
                h_count <= last_col ? '0 : h_count + 1'b1;
                if (last_col)
                    v_count <= last_row ? '0 : v_count + 1'b1;
            end
            if (xfer_in && !odd_col)
                pair_reg <= bus.data_in;
            if (load_out)
                bus.data_out <= quad_rnd[quad_w-1:2];
            bus.valid_out <= load_out || (bus.valid_out && !bus.ready_in);
        end
endmodule

// File: tb/tb_downscale_avg.sv
// tb_downscale_avg: randomized self-checking bench against a quad-average reference model.
module tb_downscale_avg;
    localparam int BD = 8;
    localparam int HR = 4;
    localparam int VR = 4;
    localparam int NP = HR * VR;
    localparam int NQ = (HR / 2) * (VR / 2);

    typedef logic [BD-1:0] frame_t [NP];

    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [BD-1:0] got[$];
    int fd_cnt = 0;
    int fd_at = 0;

    downscale_avg_if #(.bit_depth(BD)) bus ();

    downscale_avg #(
        .bit_depth(BD),
        .h_res    (HR),
        .v_res    (VR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Record every accepted output and where in the stream frame_done fired.
    always @(negedge clk) begin
        if (bus.valid_out && bus.ready_in)
            got.push_back(bus.data_out);
        if (bus.frame_done) begin
            fd_cnt++;
            fd_at = got.size();
        end
    end

    function automatic int quad_avg(input frame_t f, input int q);
        int base = (q / (HR / 2)) * 2 * HR + (q % (HR / 2)) * 2;
        int s = int'(f[base]) + int'(f[base + 1]) + int'(f[base + HR]) + int'(f[base + HR + 1]);
        return (s + 2) / 4;
    endfunction

    function automatic frame_t ramp();
        frame_t f;
        for (int i = 0; i < NP; i++)
            f[i] = BD'(i);
        return f;
    endfunction

    task automatic send_frame(input frame_t f, input int npix, input int max_gap);
        for (int i = 0; i < npix; i++) begin
            int g;
            logic acc;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            bus.valid_in = 1'b0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            bus.valid_in = 1'b1;
            bus.data_in = f[i];
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = bus.ready_out;
                @(posedge clk);
                #1;
            end
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        for (int t = 0; t < 300 && got.size() < n; t++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.valid_in = 1'b0;
        bus.data_in = '0;
        bus.ready_in = 1'b1;
        reset = 1'b0;
        #2;
        n_chk++;
        if (bus.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_out: got %0b expected 0", bus.valid_out);
        end
        n_chk++;
        if (bus.data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_data_out: got %0d expected 0", bus.data_out);
        end
        n_chk++;
        if (bus.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_frame_done: got %0b expected 0", bus.frame_done);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (bus.ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_out: got %0b expected 1", bus.ready_out);
        end
    endtask

    task automatic run_frame(input string name, input frame_t f, input int max_gap);
        int b = got.size();
        int fb = fd_cnt;
        send_frame(f, NP, max_gap);
        wait_outputs(b + NQ);
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (got.size() !== b + NQ) begin
            n_fail++;
            $display("FAIL %s_count: got %0d outputs expected %0d", name, got.size() - b, NQ);
        end
        for (int q = 0; q < NQ; q++) begin
            logic [BD-1:0] e = BD'(quad_avg(f, q));
            n_chk++;
            if (got.size() <= b + q || got[b + q] !== e) begin
                n_fail++;
                $display("FAIL %s_out%0d: got %0d expected %0d", name, q,
                         (got.size() > b + q) ? int'(got[b + q]) : -1, e);
            end
        end
        n_chk++;
        if (fd_cnt - fb !== 1 || fd_at !== b + NQ) begin
            n_fail++;
            $display("FAIL %s_frame_done: got %0d pulses at output %0d expected 1 at %0d",
                     name, fd_cnt - fb, fd_at - b, NQ);
        end
    endtask

    task automatic test_ramp();
        bus.ready_in = 1'b1;
        run_frame("ramp", ramp(), 0);
    endtask

    task automatic test_saturate();
        frame_t f;
        for (int i = 0; i < NP; i++)
            f[i] = '1;
        bus.ready_in = 1'b1;
        run_frame("saturate", f, 0);
    endtask

    task automatic test_rounding();
        frame_t f = '{8'd1, 8'd0, 8'd1, 8'd0,
                      8'd0, 8'd1, 8'd0, 8'd0,
                      8'd2, 8'd1, 8'd3, 8'd3,
                      8'd0, 8'd0, 8'd3, 8'd2};
        bus.ready_in = 1'b1;
        run_frame("rounding", f, 0);
    endtask

    task automatic test_backpressure();
        frame_t f = ramp();
        logic [BD-1:0] e0 = BD'(quad_avg(f, 0));
        int b = got.size();
        bus.ready_in = 1'b0;
        fork
            send_frame(f, NP, 0);
            begin
                int t = 0;
                @(negedge clk);
                while (!bus.valid_out && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                repeat (5) begin
                    n_chk++;
                    if (bus.data_out !== e0 || bus.valid_out !== 1'b1 || bus.ready_out !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_hold: got data %0d valid %0b ready_out %0b expected data %0d valid 1 ready_out 0",
                                 bus.data_out, bus.valid_out, bus.ready_out, e0);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.ready_in = 1'b1;
            end
        join
        wait_outputs(b + NQ);
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (got.size() !== b + NQ) begin
            n_fail++;
            $display("FAIL stall_count: got %0d outputs expected %0d", got.size() - b, NQ);
        end
        for (int q = 0; q < NQ; q++) begin
            logic [BD-1:0] e = BD'(quad_avg(f, q));
            n_chk++;
            if (got.size() <= b + q || got[b + q] !== e) begin
                n_fail++;
                $display("FAIL stall_out%0d: got %0d expected %0d", q,
                         (got.size() > b + q) ? int'(got[b + q]) : -1, e);
            end
        end
    endtask

    task automatic test_gaps();
        bus.ready_in = 1'b1;
        run_frame("gaps", ramp(), 3);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            frame_t f;
            logic done = 1'b0;
            int b = got.size();
            int fb = fd_cnt;
            for (int i = 0; i < NP; i++)
                f[i] = BD'($urandom);
            fork
                begin
                    send_frame(f, NP, 2);
                    done = 1'b1;
                end
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.ready_in = 1'($urandom_range(0, 1));
                end
            join
            bus.ready_in = 1'b1;
            wait_outputs(b + NQ);
            repeat (2) @(posedge clk);
            #1;
            n_chk++;
            if (got.size() !== b + NQ) begin
                n_fail++;
                $display("FAIL random%0d_count: got %0d outputs expected %0d", k, got.size() - b, NQ);
            end
            for (int q = 0; q < NQ; q++) begin
                logic [BD-1:0] e = BD'(quad_avg(f, q));
                n_chk++;
                if (got.size() <= b + q || got[b + q] !== e) begin
                    n_fail++;
                    $display("FAIL random%0d_out%0d: got %0d expected %0d", k, q,
                             (got.size() > b + q) ? int'(got[b + q]) : -1, e);
                end
            end
            n_chk++;
            if (fd_cnt - fb !== 1) begin
                n_fail++;
                $display("FAIL random%0d_frame_done: got %0d pulses expected 1", k, fd_cnt - fb);
            end
        end
    endtask

    task automatic test_mid_reset();
        bus.ready_in = 1'b0;
        send_frame(ramp(), 6, 0);
        n_chk++;
        if (bus.valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pending: got valid_out %0b expected 1", bus.valid_out);
        end
        reset = 1'b0;
        #1;
        n_chk++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== '0) begin
            n_fail++;
            $display("FAIL midreset_async_clear: got valid %0b data %0d expected valid 0 data 0",
                     bus.valid_out, bus.data_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.ready_in = 1'b1;
        @(posedge clk);
        #1;
        run_frame("midreset", ramp(), 0);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_saturate();
        test_rounding();
        test_backpressure();
        test_gaps();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
